// File: rtl/clutter_pkg.sv
// Shared types and constants for the clutter sweep generator.
package clutter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam int          AZ_BITS_DEF  = 12;
  localparam int          SAMPLE_W_DEF = 8;
  localparam int          ATT_W        = 3;

endpackage

// File: rtl/pulse_sync.sv
// Multi-flop synchronizer followed by a registered rising-edge detector;
// a level rising on din yields a one-cycle pulse STAGES+1 cycles later.
module pulse_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [STAGES-1:0] sync_p0;
  logic              lvl_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      lvl_p1  <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_p0 <= (sync_p0 << 1) | STAGES'(din);
      // edge stage: compare the synchronized level against its previous value
      lvl_p1  <= sync_p0[STAGES-1];
      pulse   <= sync_p0[STAGES-1] & ~lvl_p1;
    end
  end

endmodule

// File: rtl/clutter_sweep_gen.sv
// Azimuth tracker plus triggered sea-clutter sweep generator (valid/ready).
// Optional macro CLUTTER_AZ_MOD_EN adds one extra attenuation step on the downwind half.
module clutter_sweep_gen
  import clutter_pkg::*;
#(
  parameter int          AZ_BITS     = AZ_BITS_DEF,
  parameter int          RANGE_BINS  = 512,
  parameter int          SAMPLE_W    = SAMPLE_W_DEF,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                acp,
  input  logic                arp,
  input  logic                trig,
  output logic [SAMPLE_W-1:0] smp_data,
  output logic                smp_valid,
  input  logic                smp_ready,
  output logic                smp_last,
  output logic [AZ_BITS-1:0]  smp_az,
  output logic [AZ_BITS-1:0]  az_count,
  output logic                az_locked,
  output logic                arp_err,
  output logic                sweep_ovr
);

  localparam int IDX_W = $clog2(RANGE_BINS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RANGE_BINS - 1);

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  function automatic logic [ATT_W-1:0] att_plus_one(input logic [ATT_W-1:0] a);
    return (&a) ? a : a + 1'b1;
  endfunction

  logic acp_e, arp_e, trig_e;

  pulse_sync #(.STAGES(SYNC_STAGES)) u_acp_sync  (.clk(clk), .rst(rst), .din(acp),  .pulse(acp_e));
  pulse_sync #(.STAGES(SYNC_STAGES)) u_arp_sync  (.clk(clk), .rst(rst), .din(arp),  .pulse(arp_e));
  pulse_sync #(.STAGES(SYNC_STAGES)) u_trig_sync (.clk(clk), .rst(rst), .din(trig), .pulse(trig_e));

  // ARP is consistent only when it lands where the counter would wrap anyway.
  always_ff @(posedge clk) begin
    if (rst) begin
      az_count  <= '0;
      az_locked <= 1'b0;
      arp_err   <= 1'b0;
    end else begin
      arp_err <= 1'b0;
      if (arp_e) begin
        az_count <= '0;
        if ((&az_count) || !az_locked) begin
          az_locked <= 1'b1;
        end else begin
          az_locked <= 1'b0;
          arp_err   <= 1'b1;
        end
      end else if (acp_e) begin
        az_count <= az_count + 1'b1;
      end
    end
  end

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt;
  logic [15:0]        lfsr, lfsr_nxt;
  logic [AZ_BITS-1:0] az_lat_nxt;
  logic               hs;

  assign smp_valid = (state == SWEEP);
  assign hs        = smp_valid & smp_ready;

  always_comb begin
    state_nxt  = state;
    idx_nxt    = idx;
    lfsr_nxt   = lfsr;
    az_lat_nxt = smp_az;
    case (state)
      IDLE: begin
        if (trig_e && az_locked) begin
          az_lat_nxt = az_count;
          idx_nxt    = '0;
          state_nxt  = SWEEP;
        end
      end
      SWEEP: begin
        if (hs) begin
          lfsr_nxt = lfsr_step(lfsr);
          idx_nxt  = idx + 1'b1;
          if (idx == LAST_IDX) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      lfsr      <= LFSR_SEED;
      smp_az    <= '0;
      sweep_ovr <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      lfsr      <= lfsr_nxt;
      smp_az    <= az_lat_nxt;
      sweep_ovr <= trig_e && (state == SWEEP);
    end
  end

  // Range attenuation: the top bits of the bin index select the shift.
  logic [ATT_W-1:0]    att, att_eff;
  logic [SAMPLE_W-1:0] noise;

  assign att   = idx[IDX_W-1 -: ATT_W];
  assign noise = lfsr[SAMPLE_W-1:0];

`ifdef CLUTTER_AZ_MOD_EN
  assign att_eff = smp_az[AZ_BITS-1] ? att_plus_one(att) : att;
`else
  assign att_eff = att;
`endif

  assign smp_data = smp_valid ? (noise >> att_eff) : '0;
  assign smp_last = smp_valid && (idx == LAST_IDX);

endmodule

// File: tb/tb_clutter_sweep_gen.sv
// Directed bench for clutter_sweep_gen: azimuth table plus sweep scenarios.
module tb_clutter_sweep_gen;

  localparam int AZB  = 12;
  localparam int NB   = 512;
  localparam int SYNC = 2;

  logic            clk = 1'b0;
  logic            rst, acp, arp, trig, smp_ready;
  logic [7:0]      smp_data;
  logic            smp_valid, smp_last, az_locked, arp_err, sweep_ovr;
  logic [AZB-1:0]  smp_az, az_count;

  clutter_sweep_gen dut (
    .clk(clk), .rst(rst), .acp(acp), .arp(arp), .trig(trig),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .smp_last(smp_last), .smp_az(smp_az), .az_count(az_count),
    .az_locked(az_locked), .arp_err(arp_err), .sweep_ovr(sweep_ovr)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  int val_cnt = 0;
  logic [7:0] lfsr_byte [NB];

  always @(negedge clk) begin
    if (arp_err)   err_cnt++;
    if (sweep_ovr) ovr_cnt++;
    if (smp_valid) val_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic int exp_sample(input int k, input int az);
    int sh;
    sh = k >> 6;
`ifdef CLUTTER_AZ_MOD_EN
    if (az >= 2048) sh = (sh == 7) ? 7 : sh + 1;
`endif
    return int'(lfsr_byte[k]) >> sh;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; acp = 1'b0; arp = 1'b0; trig = 1'b0; smp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic acp_pulse(input bit with_arp);
    @(negedge clk);
    acp = 1'b1; arp = with_arp;
    repeat (2) @(negedge clk);
    acp = 1'b0; arp = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic lock_at(input int n);
    acp_pulse(1'b1);
    for (int i = 0; i < n; i++) acp_pulse(1'b0);
    repeat (4) @(negedge clk);
    chk("lock_az", az_count, n);
    chk("lock_locked", az_locked, 1);
  endtask

  // mode 0: ready held high; mode 1: random ready. ovr_bin/rst_bin < 0 disables.
  task automatic do_sweep(input int mode, input int exp_az, input int ovr_bin, input int rst_bin);
    int cyc, hs, first_v, ovr_start, ovr_base;
    bit stalled, aborted;
    logic [7:0] h_data;
    logic h_last;
    logic [AZB-1:0] h_az;
    cyc = 0; hs = 0; first_v = -1; ovr_start = -1; stalled = 0; aborted = 0;
    h_data = '0; h_last = 1'b0; h_az = '0;
    ovr_base = ovr_cnt;
    @(negedge clk);
    trig = 1'b1;
    while (hs < NB && cyc < 4000 && !aborted) begin
      @(negedge clk);
      cyc++;
      if (ovr_bin >= 0 && hs == ovr_bin && ovr_start < 0) ovr_start = cyc;
      trig = (cyc < 3) || (ovr_start >= 0 && cyc < ovr_start + 3);
      if (smp_valid && first_v < 0) begin
        first_v = cyc;
        chk("valid_latency", first_v, SYNC + 2);
        chk("first_sample", smp_data, exp_sample(0, exp_az));
      end
      if (stalled) begin
        chk("stall_valid", smp_valid, 1);
        chk("stall_data", smp_data, h_data);
        chk("stall_last", smp_last, h_last);
        chk("stall_az", smp_az, h_az);
      end
      smp_ready = (mode == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
      stalled = 0;
      if (smp_valid) begin
        if (smp_ready) begin
          chk($sformatf("data_bin%0d", hs), smp_data, exp_sample(hs, exp_az));
          chk($sformatf("last_bin%0d", hs), smp_last, (hs == NB - 1) ? 1 : 0);
          chk("smp_az", smp_az, exp_az);
          hs++;
        end else begin
          stalled = 1;
          h_data = smp_data; h_last = smp_last; h_az = smp_az;
        end
      end
      if (rst_bin >= 0 && hs == rst_bin) begin
        rst = 1'b1;
        aborted = 1;
      end
    end
    @(negedge clk);
    chk("valid_drop", smp_valid, 0);
    rst = 1'b0; trig = 1'b0; smp_ready = 1'b0;
    if (!aborted) begin
      chk("handshakes", hs, NB);
      chk("ovr_pulses", ovr_cnt - ovr_base, (ovr_bin >= 0) ? 1 : 0);
    end
    repeat (4) @(negedge clk);
  endtask

  typedef struct {
    int n_acp;
    bit arp_last;
    int az;
    bit locked;
    int errs;
  } az_vec_t;

  az_vec_t tbl [7];

  initial begin
    logic [15:0] l;
    int base, vbase, obase;
    tbl[0] = '{4095, 1'b0, 4095, 1'b0, 0};
    tbl[1] = '{1,    1'b1, 0,    1'b1, 0};
    tbl[2] = '{100,  1'b0, 100,  1'b1, 0};
    tbl[3] = '{1,    1'b1, 0,    1'b0, 1};
    tbl[4] = '{5,    1'b0, 5,    1'b0, 0};
    tbl[5] = '{1,    1'b1, 0,    1'b1, 0};
    tbl[6] = '{37,   1'b0, 37,   1'b1, 0};

    l = 16'hACE1;
    for (int k = 0; k < NB; k++) begin
      lfsr_byte[k] = l[7:0];
      l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
    end

    rst = 1'b1; acp = 1'b0; arp = 1'b0; trig = 1'b0; smp_ready = 1'b0;
    do_reset();
    chk("rst_valid", smp_valid, 0);
    chk("rst_data", smp_data, 0);
    chk("rst_last", smp_last, 0);
    chk("rst_smp_az", smp_az, 0);
    chk("rst_az_count", az_count, 0);
    chk("rst_locked", az_locked, 0);
    chk("rst_arp_err", arp_err, 0);
    chk("rst_ovr", sweep_ovr, 0);

    // Trigger before any ARP must be ignored.
    vbase = val_cnt; obase = ovr_cnt;
    @(negedge clk); trig = 1'b1;
    repeat (3) @(negedge clk); trig = 1'b0;
    repeat (10) @(negedge clk);
    chk("unlocked_valid", val_cnt - vbase, 0);
    chk("unlocked_ovr", ovr_cnt - obase, 0);

    for (int v = 0; v < 7; v++) begin
      base = err_cnt;
      for (int i = 0; i < tbl[v].n_acp; i++)
        acp_pulse(tbl[v].arp_last && (i == tbl[v].n_acp - 1));
      repeat (4) @(negedge clk);
      chk($sformatf("tbl%0d_az", v), az_count, tbl[v].az);
      chk($sformatf("tbl%0d_locked", v), az_locked, tbl[v].locked);
      chk($sformatf("tbl%0d_errs", v), err_cnt - base, tbl[v].errs);
    end

    do_sweep(0, 37, -1, -1);

    do_reset(); lock_at(37);
    do_sweep(1, 37, -1, -1);

    do_reset(); lock_at(37);
    do_sweep(0, 37, 200, -1);

    do_reset(); lock_at(37);
    do_sweep(0, 37, -1, 300);
    lock_at(37);
    do_sweep(0, 37, -1, -1);

    do_reset(); lock_at(2048);
    do_sweep(0, 2048, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
